// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory initiator: sign/zero-extended loads, word stores, RMW sub-word stores.
// Define LSU_SUBWORD_STORE_EN to enable SB/SH read-modify-write; otherwise SB/SH return an error.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_writeData,
  output logic              mem_memRead,
  output logic              mem_memWrite,
  input  logic [31:0]       mem_readData
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        op_q, op_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic        accept;
  logic        op_legal;
  logic        misaligned;
  logic        sub_store;
  logic        req_err;
  logic [4:0]  ld_lsb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] wr_word;

  assign accept    = req_valid && (state_q == S_IDLE);
  assign sub_store = req_we && ((req_op == 3'b000) || (req_op == 3'b001));

  // Unsigned variants exist only for loads; 011 and 11x are never legal.
  always_comb begin
    op_legal = 1'b0;
    case (req_op)
      3'b000, 3'b001, 3'b010: op_legal = 1'b1;
      3'b100, 3'b101:         op_legal = !req_we;
      default:                op_legal = 1'b0;
    endcase
`ifndef LSU_SUBWORD_STORE_EN
    if (sub_store) op_legal = 1'b0;
`endif
  end

  assign misaligned = ((req_op[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_op == 3'b010) && (req_addr[1:0] != 2'b00));
  assign req_err    = !op_legal || misaligned;

  always_comb begin
    ld_lsb  = {addr_q[1:0], 3'b000};
    ld_byte = mem_readData[ld_lsb +: 8];
    ld_half = addr_q[1] ? mem_readData[31:16] : mem_readData[15:0];
    case (op_q[1:0])
      2'b00:   ld_ext = {{24{ld_byte[7] & ~op_q[2]}}, ld_byte};
      2'b01:   ld_ext = {{16{ld_half[15] & ~op_q[2]}}, ld_half};
      default: ld_ext = mem_readData;
    endcase
  end

`ifdef LSU_SUBWORD_STORE_EN
  logic [31:0] rd_word_q, rd_word_d;
  logic [31:0] merged;

  // Replace only the addressed lane of the word captured during RD.
  always_comb begin
    merged = rd_word_q;
    if (op_q[0]) begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end else begin
      merged[ld_lsb +: 8] = wdata_q[7:0];
    end
  end

  assign wr_word = op_q[1] ? wdata_q : merged;
`else
  assign wr_word = wdata_q;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    op_d         = op_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
`ifdef LSU_SUBWORD_STORE_EN
    rd_word_d    = rd_word_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d     = req_addr;
          op_d       = req_op;
          we_d       = req_we;
          wdata_d    = req_wdata;
          resp_err_d = req_err;
          if (req_err)        state_d = S_RESP;
          else if (!req_we)   state_d = S_RD;
          else if (sub_store) state_d = S_RD;
          else                state_d = S_WR;
        end
      end
      S_RD: begin
`ifdef LSU_SUBWORD_STORE_EN
        if (we_q) begin
          rd_word_d = mem_readData;
          state_d   = S_WR;
        end else begin
          resp_rdata_d = ld_ext;
          state_d      = S_RESP;
        end
`else
        resp_rdata_d = ld_ext;
        state_d      = S_RESP;
`endif
      end
      S_WR:    state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      op_q         <= 3'b000;
      we_q         <= 1'b0;
      wdata_q      <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
`ifdef LSU_SUBWORD_STORE_EN
      rd_word_q    <= 32'h0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      op_q         <= op_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
`ifdef LSU_SUBWORD_STORE_EN
      rd_word_q    <= rd_word_d;
`endif
    end
  end

  // Memory side decodes only from state and registered fields.
  assign req_ready     = (state_q == S_IDLE);
  assign resp_valid    = (state_q == S_RESP);
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;
  assign mem_memRead   = (state_q == S_RD);
  assign mem_memWrite  = (state_q == S_WR);
  assign mem_address   = (mem_memRead || mem_memWrite) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_writeData = mem_memWrite ? wr_word : 32'h0;

endmodule
